// File: rtl/fifo_drain_pkg.sv
// Shared types and defaults for the FIFO read-side drain sequencer.
// Optional feature macro: DRAIN_GAP_EN (inter-word idle gap).
package fifo_drain_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } drain_state_t;

    localparam int unsigned DEF_ACK_TIMEOUT = 16;
    localparam int unsigned DEF_MAX_RETRY   = 3;
    localparam int unsigned DEF_GAP_CYCLES  = 4;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_drain_ctrl_timer.sv
// Loadable down-counter with a terminal-count flag.
module drain_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             R_CLK,
    input  logic             R_RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side sequencer: pops FIFO words and hands them to a busy-flagged
// serial consumer with retry, flush and a delivered-word counter.
// Optional feature macro: DRAIN_GAP_EN (idle gap after each TX_BUSY fall).
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int unsigned D_WIDTH     = 8,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                 R_CLK,
    input  logic                 R_RST,
    input  logic                 R_EMPTY,
    input  logic [D_WIDTH-1:0]   R_DATA,
    output logic                 R_INC,
    input  logic                 TX_BUSY,
    output logic                 TX_VALID,
    output logic [D_WIDTH-1:0]   TX_DATA,
    input  logic                 FLUSH,
    output logic [CNT_WIDTH-1:0] DRAIN_CNT,
    output logic                 DROP_ERR
);

    localparam int unsigned ACK_W = width_for(ACK_TIMEOUT);
    localparam int unsigned RTY_W = width_for(MAX_RETRY + 1);
    // TX_VALID pulses are ACK_TIMEOUT cycles apart: SEND plus ACK_TIMEOUT-1 WAIT_ACK cycles.
    localparam logic [ACK_W-1:0] ACK_RELOAD = ACK_W'(ACK_TIMEOUT - 2);
    localparam logic [RTY_W-1:0] RTY_LIMIT  = RTY_W'(MAX_RETRY);

    // Reject configurations the timers cannot represent.
    if ((ACK_TIMEOUT < 2) || (MAX_RETRY < 1) || (GAP_CYCLES < 1)) begin : g_bad_cfg
        $error("fifo_drain_ctrl: ACK_TIMEOUT>=2, MAX_RETRY>=1, GAP_CYCLES>=1 required");
    end

    drain_state_t           state_q;
    drain_state_t           state_d;
    logic [D_WIDTH-1:0]     tx_data_q;
    logic [CNT_WIDTH-1:0]   drain_cnt_q;
    logic [RTY_W-1:0]       retry_q;
    logic                   drop_err_q;
    logic                   ack_tc;
    logic                   ack_hit_c;
    logic                   retry_c;
    logic                   drop_c;

    // Ack timer: reloaded in SEND, runs down while waiting for TX_BUSY.
    drain_timer #(
        .WIDTH (ACK_W)
    ) u_ack_timer (
        .R_CLK    (R_CLK),
        .R_RST    (R_RST),
        .load     (state_q == SEND),
        .load_val (ACK_RELOAD),
        .dec      (state_q == WAIT_ACK),
        .tc       (ack_tc)
    );

`ifdef DRAIN_GAP_EN
    localparam int unsigned GAP_W = width_for(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

    logic gap_tc;

    // Gap timer: armed while the consumer is busy, runs down in GAP.
    drain_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .R_CLK    (R_CLK),
        .R_RST    (R_RST),
        .load     (state_q == WAIT_DONE),
        .load_val (GAP_RELOAD),
        .dec      (state_q == GAP),
        .tc       (gap_tc)
    );
`endif

    // State register.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus single-cycle event strobes for the datapath.
    always_comb begin
        state_d   = state_q;
        ack_hit_c = 1'b0;
        retry_c   = 1'b0;
        drop_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (FLUSH) begin
                    state_d = IDLE;
                end else if (!R_EMPTY && !TX_BUSY) begin
                    state_d = LOAD;
                end
            end
            LOAD:     state_d = SEND;
            SEND:     state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (TX_BUSY) begin
                    ack_hit_c = 1'b1;
                    state_d   = WAIT_DONE;
                end else if (ack_tc) begin
                    if (retry_q < RTY_LIMIT) begin
                        retry_c = 1'b1;
                        state_d = SEND;
                    end else begin
                        drop_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
`ifdef DRAIN_GAP_EN
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef DRAIN_GAP_EN
            GAP: begin
                if (gap_tc) begin
                    state_d = IDLE;
                end
            end
`endif
            default:  state_d = IDLE;
        endcase
    end

    // Output decode: Moore pop in LOAD, Mealy pop while flushing in IDLE.
    always_comb begin
        R_INC    = 1'b0;
        TX_VALID = 1'b0;
        if (!R_RST) begin
            R_INC = (state_q == LOAD) ||
                    ((state_q == IDLE) && FLUSH && !R_EMPTY);
        end
        TX_VALID = (state_q == SEND);
    end

    // Datapath: captured word, retry count, delivered count, drop pulse.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            tx_data_q   <= '0;
            retry_q     <= '0;
            drain_cnt_q <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            drop_err_q <= drop_c;
            if (state_q == LOAD) begin
                tx_data_q <= R_DATA;
                retry_q   <= '0;
            end else if (retry_c) begin
                retry_q <= retry_q + RTY_W'(1);
            end
            if (ack_hit_c) begin
                drain_cnt_q <= drain_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign TX_DATA   = tx_data_q;
    assign DRAIN_CNT = drain_cnt_q;
    assign DROP_ERR  = drop_err_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: a FIFO model feeds the DUT, a
// consumer model answers TX_VALID, and a monitor checks every delivered word.
module tb_fifo_drain_ctrl;

`ifdef DRAIN_GAP_EN
    localparam int EXP_GAP = 6;
`else
    localparam int EXP_GAP = 2;
`endif

    logic       clk;
    logic       rst;
    logic       r_empty;
    logic [7:0] r_data;
    logic       r_inc;
    logic       tx_busy;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       flush;
    logic [7:0] drain_cnt;
    logic       drop_err;

    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;

    logic [7:0] exp_q [$];
    int         valid_times [$];

    int n_pass = 0;
    int n_total = 0;
    int n_valid = 0;
    int n_inc = 0;
    int n_drop = 0;
    int n_fall = 0;
    int n_gap_chk = 0;
    int gap_ref = 0;
    int last_inc = 0;
    int last_valid = 0;
    int last_fall = 0;
    bit cons_ack;
    bit cons_idle;
    bit chk_gap;
    int busy_len;

    fifo_drain_ctrl #(
        .D_WIDTH     (8),
        .CNT_WIDTH   (8),
        .ACK_TIMEOUT (16),
        .MAX_RETRY   (3),
        .GAP_CYCLES  (4)
    ) dut (
        .R_CLK     (clk),
        .R_RST     (rst),
        .R_EMPTY   (r_empty),
        .R_DATA    (r_data),
        .R_INC     (r_inc),
        .TX_BUSY   (tx_busy),
        .TX_VALID  (tx_valid),
        .TX_DATA   (tx_data),
        .FLUSH     (flush),
        .DRAIN_CNT (drain_cnt),
        .DROP_ERR  (drop_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: combinational head word, popped on R_INC.
    assign r_empty = (wr_ptr == rd_ptr);
    assign r_data  = mem[rd_ptr[9:0]];
    always @(posedge clk) if (r_inc) rd_ptr <= rd_ptr + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    task automatic push(input logic [7:0] d, input int n_exp);
        mem[wr_ptr[9:0]] = d;
        wr_ptr = wr_ptr + 1;
        for (int k = 0; k < n_exp; k++) exp_q.push_back(d);
    endtask

    task automatic wait_drained(input string name, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 6 && n < budget) begin
            @(negedge clk);
            n++;
            if (r_empty && !tx_busy && cons_idle) quiet++;
            else quiet = 0;
        end
        check({name, "_drained"}, 32'(quiet >= 6), 1);
    endtask

    // Consumer: raise TX_BUSY two cycles after TX_VALID, hold busy_len cycles.
    initial begin
        tx_busy   = 1'b0;
        cons_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_valid && cons_ack && !rst) begin
                cons_idle = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
                last_fall = cyc;
                n_fall++;
                cons_idle = 1'b1;
            end
        end
    end

    // Monitor: pop the scoreboard on every TX_VALID, log pops and drops.
    initial begin
        logic [7:0] exp_d;
        forever begin
            @(negedge clk);
            if (!chk_gap) gap_ref = n_fall;
            if (!rst) begin
                if (tx_valid) begin
                    n_valid++;
                    last_valid = cyc;
                    valid_times.push_back(cyc);
                    check("sb_has_entry", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_d = exp_q.pop_front();
                        check("tx_data", 32'(tx_data), 32'(exp_d));
                    end
                end
                if (r_inc) begin
                    n_inc++;
                    last_inc = cyc;
                    if (chk_gap && (n_fall != gap_ref)) begin
                        n_gap_chk++;
                        check("word_gap", cyc - last_fall, EXP_GAP);
                        gap_ref = n_fall;
                    end
                end
                if (drop_err) n_drop++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got %0d cycles want completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, i0, d0, g0, vidx, n, push_cyc, drop_at;
        rst = 1'b1; flush = 1'b0; cons_ack = 1'b1; busy_len = 10; chk_gap = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_r_inc",     32'(r_inc), 0);
        check("rst_tx_valid",  32'(tx_valid), 0);
        check("rst_tx_data",   32'(tx_data), 0);
        check("rst_drain_cnt", 32'(drain_cnt), 0);
        check("rst_drop_err",  32'(drop_err), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single word 0xA5.
        repeat (2) @(posedge clk); #1;
        v0 = n_valid; i0 = n_inc; push_cyc = cyc;
        push(8'hA5, 1);
        wait_drained("t1", 200);
        check("t1_inc_count",   n_inc - i0, 1);
        check("t1_valid_count", n_valid - v0, 1);
        check("t1_inc_latency", last_inc - push_cyc, 1);
        check("t1_valid_after_inc", last_valid - last_inc, 1);
        check("t1_drain_cnt",   32'(drain_cnt), 1);
        check("t1_tx_data",     32'(tx_data), 32'h A5);
        check("t1_r_inc_idle",  32'(r_inc), 0);

        // Three words back to back; spacing from TX_BUSY fall to next pop.
        @(posedge clk); #1;
        chk_gap = 1'b1; v0 = n_valid; g0 = n_gap_chk;
        push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
        wait_drained("t2", 400);
        chk_gap = 1'b0;
        check("t2_valid_count", n_valid - v0, 3);
        check("t2_gap_checks",  n_gap_chk - g0, 2);
        check("t2_drain_cnt",   32'(drain_cnt), 4);

        // Silent consumer: four pulses, drop, then next word delivered.
        @(posedge clk); #1;
        cons_ack = 1'b0; vidx = valid_times.size(); d0 = n_drop;
        push(8'h5C, 4); push(8'h6D, 1);
        n = 0;
        while (!drop_err && n < 300) begin @(negedge clk); n++; end
        check("t3_drop_seen", 32'(drop_err), 1);
        drop_at = cyc;
        check("t3_cnt_hold", 32'(drain_cnt), 4);
        cons_ack = 1'b1;
        check("t3_pulses", valid_times.size() - vidx, 4);
        if (valid_times.size() >= vidx + 4) begin
            for (int k = 1; k < 4; k++)
                check("t3_spacing", valid_times[vidx + k] - valid_times[vidx + k - 1], 16);
            check("t3_drop_delay", drop_at - valid_times[vidx + 3], 16);
        end
        wait_drained("t3", 300);
        check("t3_drop_count", n_drop - d0, 1);
        check("t3_drain_cnt",  32'(drain_cnt), 5);
        check("t3_next_word",  32'(tx_data), 32'h6D);

        // Flush five words while idle.
        @(posedge clk); #1;
        v0 = n_valid; i0 = n_inc; push_cyc = cyc;
        flush = 1'b1;
        for (int k = 0; k < 5; k++) push(8'(8'hE0 + k), 0);
        repeat (10) @(negedge clk);
        check("t4_inc_count",   n_inc - i0, 5);
        check("t4_consecutive", last_inc - push_cyc, 4);
        check("t4_no_valid",    n_valid - v0, 0);
        check("t4_empty",       32'(r_empty), 1);
        @(posedge clk); #1 flush = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_no_pop_after", n_inc - i0, 5);

        // Reset while the consumer is busy, then resume.
        @(posedge clk); #1;
        push(8'h77, 1);
        n = 0;
        while (!tx_busy && n < 50) begin @(negedge clk); n++; end
        check("t5_busy_seen", 32'(tx_busy), 1);
        @(posedge clk); #1;
        check("t5_cnt_before", 32'(drain_cnt), 6);
        rst = 1'b1;
        #1;
        check("t5_rst_r_inc",     32'(r_inc), 0);
        check("t5_rst_tx_valid",  32'(tx_valid), 0);
        check("t5_rst_tx_data",   32'(tx_data), 0);
        check("t5_rst_drain_cnt", 32'(drain_cnt), 0);
        check("t5_rst_drop_err",  32'(drop_err), 0);
        repeat (2) @(posedge clk); #1 rst = 1'b0;
        wait_drained("t5_quiet", 100);
        @(posedge clk); #1;
        push(8'h88, 1);
        wait_drained("t5", 200);
        check("t5_drain_cnt", 32'(drain_cnt), 1);
        check("t5_tx_data",   32'(tx_data), 32'h88);

        // Counter wrap: 257 words delivered since reset.
        busy_len = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 254; k++) push(8'(k) ^ 8'h3C, 1);
        wait_drained("t6a", 4000);
        check("t6_cnt_255", 32'(drain_cnt), 255);
        @(posedge clk); #1;
        push(8'hC3, 1); push(8'h96, 1);
        wait_drained("t6b", 200);
        check("t6_cnt_wrap", 32'(drain_cnt), 1);

        check("sb_all_delivered", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side sequencer for the asynchronous FIFO in the R_CLK domain. It pops one word at a time when the FIFO is non-empty and hands it to a busy-flagged serial consumer such as the UART TX, using a one-cycle valid pulse. It tracks the consumer's busy flag, retries on a missed handshake, supports a flush that discards FIFO contents, and keeps a count of delivered words.

## Interface
- D_WIDTH, 8, FIFO data and consumer data width
- CNT_WIDTH, 8, width of delivered-word counter
- ACK_TIMEOUT, 16, R_CLK cycles to wait for TX_BUSY rise before re-pulsing TX_VALID (≥2)
- MAX_RETRY, 3, re-pulses before dropping the word
- GAP_CYCLES, 4, idle cycles inserted between words (used only with gap feature)

- R_CLK  in  1  read-domain clock
- R_RST  in  1  reset, asynchronous, active-high
- R_EMPTY  in  1  FIFO empty flag
- R_DATA  in  D_WIDTH  FIFO read data at current read address, combinationally valid while R_EMPTY=0
- R_INC  out  1  FIFO pop strobe, one cycle per word
- TX_BUSY  in  1  consumer busy, high while a word is transmitted
- TX_VALID  out  1  one-cycle pulse, TX_DATA valid
- TX_DATA  out  D_WIDTH  registered word for consumer
- FLUSH  in  1  level; discard FIFO contents while high
- DRAIN_CNT  out  CNT_WIDTH  words acknowledged by consumer, wraps modulo 2^CNT_WIDTH
- DROP_ERR  out  1  one-cycle pulse when a word is dropped after MAX_RETRY re-pulses

## Operation
- States: IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: if FLUSH=1 and R_EMPTY=0 → R_INC=1 combinationally this cycle, stay IDLE (one word discarded per cycle, no TX_VALID). Else if R_EMPTY=0 and TX_BUSY=0 → LOAD. Otherwise stay in IDLE.
- LOAD: R_INC=1 for exactly this cycle; TX_DATA <= R_DATA; → SEND. R_INC never asserts when R_EMPTY=1.
- SEND: TX_VALID=1 for one cycle; clear ack timer; → WAIT_ACK.
- WAIT_ACK: TX_BUSY=1 → WAIT_DONE, DRAIN_CNT += 1. Timer reaching ACK_TIMEOUT-1 with retries<MAX_RETRY → retries += 1, → SEND with the same TX_DATA. With retries=MAX_RETRY → DROP_ERR pulse, → IDLE.
- WAIT_DONE: wait for TX_BUSY=0, then → GAP if the gap feature is compiled in, else → IDLE.
- GAP: count GAP_CYCLES cycles, then → IDLE.
- Retry counter clears on every LOAD.
- FLUSH is sampled only in IDLE. An in-flight word completes normally.
- Timer widths: ceil(log2(ACK_TIMEOUT)), ceil(log2(MAX_RETRY+1)).

## Timing
- Reset values: state IDLE, R_INC=0, TX_VALID=0, TX_DATA=0, DRAIN_CNT=0, DROP_ERR=0, timers 0.
- R_INC is Moore-decoded in LOAD and Mealy in IDLE flush; all other outputs are registered or state-decoded without input paths.
- Latency from R_EMPTY falling (sampled in IDLE) to R_INC: 1 cycle. TX_VALID follows R_INC by 1 cycle.
- Minimum per-word period without the gap feature: 4 cycles plus consumer busy time.
- DRAIN_CNT updates the cycle after TX_BUSY is seen high. It wraps from 2^CNT_WIDTH-1 to 0.
- R_RST asserted mid-word: immediate return to the reset values. The FIFO word already popped is lost.
- R_EMPTY rising in the same cycle as LOAD cannot occur, because only this block pops.

## Configuration
- DRAIN_GAP_EN defined: GAP state present and GAP_CYCLES idle cycles are inserted after each TX_BUSY fall.
- DRAIN_GAP_EN undefined: GAP state and its counter are absent, and WAIT_DONE goes directly to IDLE. GAP_CYCLES is ignored.

## Structure
- Shared package fifo_drain_pkg:
  - state encoding constants: IDLE=0, LOAD=1, SEND=2, WAIT_ACK=3, WAIT_DONE=4, GAP=5 (3-bit)
  - default ACK_TIMEOUT and MAX_RETRY values.
- One sub-module, drain_timer: a loadable down-counter with a terminal-count flag. It is instantiated for the ack timeout and, under DRAIN_GAP_EN, for the gap.
- FSM, datapath register and counters stay in fifo_drain_ctrl.

## Test plan
- Reset then FIFO holds 0xA5, consumer raises TX_BUSY 2 cycles after TX_VALID for 10 cycles. Required: one R_INC, TX_DATA=0xA5, one TX_VALID, DRAIN_CNT=1, R_INC=0 afterward.
- Three words 0x11, 0x22, 0x33 back to back. Required: words delivered in order, each TX_VALID only after the previous TX_BUSY fall, DRAIN_CNT=3. With DRAIN_GAP_EN and GAP_CYCLES=4, at least 4 idle cycles between a TX_BUSY fall and the next R_INC.
- Consumer never raises TX_BUSY, ACK_TIMEOUT=16, MAX_RETRY=3. Required: 4 TX_VALID pulses 16 cycles apart, all with the same data, then a DROP_ERR pulse, DRAIN_CNT unchanged, next word loaded.
- FIFO holds 5 words, FLUSH held high in IDLE. Required: 5 consecutive R_INC cycles, no TX_VALID, stop at R_EMPTY=1.
- DRAIN_CNT preloaded near wrap (CNT_WIDTH=8, deliver 257 words). Required: DRAIN_CNT=1.
- R_RST pulsed during WAIT_DONE. Required: all outputs at reset values immediately, and normal operation resumes on the next non-empty FIFO.
